// File: rtl/icache_fetch_queue.sv
// rtl/icache_fetch_queue.sv - circular fetch-entry queue with in-place status rewrite
module icache_fetch_queue #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8,
    parameter int PTRW  = $clog2(DEPTH),
    parameter int STLO  = 2,
    parameter int STW   = 2
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             Wable,
    input  logic [WIDTH-1:0] Din,
    input  logic             Rable,
    output logic [WIDTH-1:0] FifoPreOut,
    output logic [PTRW-1:0]  FifoPrePtr,
    input  logic             StateWAble,
    input  logic [PTRW-1:0]  StatePtr,
    input  logic [STW-1:0]   StateDate,
    input  logic             FifoClean,
    output logic             FifoEmpty,
    output logic             FifoFull,
    output logic [PTRW:0]    FifoCount,
    output logic             OvfErr,
    output logic             UdfErr
);

    localparam logic [PTRW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW:0]    wp;
    logic [PTRW:0]    rp;
    logic [PTRW-1:0]  wslot;
    logic [PTRW-1:0]  rslot;
    logic             pop_ok;
    logic             push_ok;
    logic             st_ok;

    assign wslot = wp[PTRW-1:0];
    assign rslot = rp[PTRW-1:0];

    // Extra MSB on each pointer distinguishes full from empty when slots match.
    assign FifoEmpty  = (wp == rp);
    assign FifoFull   = (wslot == rslot) && (wp[PTRW] != rp[PTRW]);
    assign FifoCount  = wp - rp;
    assign FifoPreOut = mem[rslot];
    assign FifoPrePtr = rslot;

    assign pop_ok  = !FifoClean && Rable && !FifoEmpty;
    assign push_ok = !FifoClean && Wable && (!FifoFull || pop_ok);
    // A push landing on the same slot overrides the status rewrite.
    assign st_ok   = !FifoClean && StateWAble && !(push_ok && (StatePtr == wslot));

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            wp <= '0;
            rp <= '0;
        end else if (FifoClean) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + PTR_ONE;
            if (pop_ok)  rp <= rp + PTR_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && (wslot == PTRW'(i)))
                    mem[i] <= Din;
                else if (st_ok && (StatePtr == PTRW'(i)))
                    mem[i][STLO +: STW] <= StateDate;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            OvfErr <= 1'b0;
            UdfErr <= 1'b0;
        end else if (FifoClean) begin
            OvfErr <= 1'b0;
            UdfErr <= 1'b0;
        end else begin
            if (Wable && FifoFull && !pop_ok) OvfErr <= 1'b1;
            if (Rable && FifoEmpty)           UdfErr <= 1'b1;
        end
    end

endmodule
